// File: rtl/fft_frame_sequencer_if.sv
// Handshake/bus bundle between the FFT frame sequencer and its environment.
// master = sequencer side, slave = source / FFT core / host side.
interface fft_frame_sequencer_if #(
  parameter int LOG2_N = 10,
  parameter int DW     = 8,
  parameter int OW     = 24,
  parameter int CFG_W  = 8
);
  logic              start;
  logic              fwd_inv;
  logic [DW-1:0]     src_tdata;
  logic              src_tvalid;
  logic              src_tready;
  logic [CFG_W-1:0]  cfg_tdata;
  logic              cfg_tvalid;
  logic              cfg_tready;
  logic [DW-1:0]     fft_s_tdata_re;
  logic              fft_s_tvalid;
  logic              fft_s_tlast;
  logic              fft_s_tready;
  logic [OW-1:0]     fft_m_tdata_re;
  logic [OW-1:0]     fft_m_tdata_im;
  logic              fft_m_tvalid;
  logic              fft_m_tlast;
  logic              fft_m_tready;
  logic [LOG2_N-1:0] peak_bin;
  logic [2*OW:0]     peak_mag;
  logic              done;
  logic              busy;
  logic              err_tlast;

  modport master (
    input  start, fwd_inv, src_tdata, src_tvalid, cfg_tready, fft_s_tready,
           fft_m_tdata_re, fft_m_tdata_im, fft_m_tvalid, fft_m_tlast,
    output src_tready, cfg_tdata, cfg_tvalid, fft_s_tdata_re, fft_s_tvalid,
           fft_s_tlast, fft_m_tready, peak_bin, peak_mag, done, busy, err_tlast
  );

  modport slave (
    output start, fwd_inv, src_tdata, src_tvalid, cfg_tready, fft_s_tready,
           fft_m_tdata_re, fft_m_tdata_im, fft_m_tvalid, fft_m_tlast,
    input  src_tready, cfg_tdata, cfg_tvalid, fft_s_tdata_re, fft_s_tvalid,
           fft_s_tlast, fft_m_tready, peak_bin, peak_mag, done, busy, err_tlast
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the streaming FFT: config word, N gated samples with tlast,
// drain of N bins with |X|^2 peak search. FFT_SEQ_CONTINUOUS_EN: free-running frames.
module fft_frame_sequencer #(
  parameter int LOG2_N = 10,
  parameter int DW     = 8,
  parameter int OW     = 24,
  parameter int CFG_W  = 8
) (
  input logic clk,
  input logic rst,
  fft_frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_LOAD, S_DRAIN, S_FLUSH1, S_FLUSH2, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                 fwd_q;
  logic [LOG2_N-1:0]    in_cnt, out_cnt;
  logic                 in_beat, out_beat, clr;

  logic                 s1_vld;
  logic signed [OW-1:0] s1_re, s1_im;
  logic [LOG2_N-1:0]    s1_bin;
  logic                 s2_vld;
  logic [2*OW:0]        s2_mag;
  logic [LOG2_N-1:0]    s2_bin;

  logic [2*OW:0]        peak_mag_q;
  logic [LOG2_N-1:0]    peak_bin_q;
  logic                 err_q;

  logic signed [2*OW-1:0] re_x, im_x, re_sq, im_sq;
  logic [2*OW:0]          mag_nxt;

  assign in_beat  = (state == S_LOAD)  && bus.src_tvalid && bus.fft_s_tready;
  assign out_beat = (state == S_DRAIN) && bus.fft_m_tvalid;

`ifdef FFT_SEQ_CONTINUOUS_EN
  assign clr = ((state == S_IDLE) && bus.start) || (state == S_DONE);
`else
  assign clr = (state == S_IDLE) && bus.start;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start)                    state_nxt = S_CFG;
      S_CFG:    if (bus.cfg_tready)               state_nxt = S_LOAD;
      S_LOAD:   if (in_beat && (in_cnt == '1))    state_nxt = S_DRAIN;
      S_DRAIN:  if (out_beat && (out_cnt == '1))  state_nxt = S_FLUSH1;
      S_FLUSH1:                                   state_nxt = S_FLUSH2;
      S_FLUSH2:                                   state_nxt = S_DONE;
`ifdef FFT_SEQ_CONTINUOUS_EN
      S_DONE:                                     state_nxt = S_CFG;
`else
      S_DONE:                                     state_nxt = S_IDLE;
`endif
      default:                                    state_nxt = S_IDLE;
    endcase
  end

  // Outputs: LOAD is a pure combinational pass-through between source and FFT
  always_comb begin
    bus.src_tready     = 1'b0;
    bus.fft_s_tdata_re = '0;
    bus.fft_s_tvalid   = 1'b0;
    bus.fft_s_tlast    = 1'b0;
    bus.cfg_tvalid     = 1'b0;
    bus.fft_m_tready   = 1'b0;
    bus.done           = 1'b0;
    bus.busy           = (state != S_IDLE);
    case (state)
      S_CFG:  bus.cfg_tvalid = 1'b1;
      S_LOAD: begin
        bus.src_tready     = bus.fft_s_tready;
        bus.fft_s_tdata_re = bus.src_tdata;
        bus.fft_s_tvalid   = bus.src_tvalid;
        bus.fft_s_tlast    = (in_cnt == '1);
      end
      S_DRAIN: bus.fft_m_tready = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.cfg_tdata = CFG_W'(fwd_q);
  assign bus.peak_mag  = peak_mag_q;
  assign bus.peak_bin  = peak_bin_q;
  assign bus.err_tlast = err_q;

  // Squares are formed at full 2*OW width so nothing is truncated
  always_comb begin
    re_x    = (2*OW)'(s1_re);
    im_x    = (2*OW)'(s1_im);
    re_sq   = re_x * re_x;
    im_sq   = im_x * im_x;
    mag_nxt = {1'b0, re_sq} + {1'b0, im_sq};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      err_q      <= 1'b0;
      peak_mag_q <= '0;
      peak_bin_q <= '0;
      s1_vld     <= 1'b0;
      s1_re      <= '0;
      s1_im      <= '0;
      s1_bin     <= '0;
      s2_vld     <= 1'b0;
      s2_mag     <= '0;
      s2_bin     <= '0;
    end else begin
      if ((state == S_IDLE) && bus.start) fwd_q <= bus.fwd_inv;

      if (clr) begin
        in_cnt     <= '0;
        out_cnt    <= '0;
        err_q      <= 1'b0;
        peak_mag_q <= '0;
        peak_bin_q <= '0;
      end else begin
        if (in_beat) in_cnt <= in_cnt + LOG2_N'(1);
        if (out_beat) begin
          out_cnt <= out_cnt + LOG2_N'(1);
          if (bus.fft_m_tlast != (out_cnt == '1)) err_q <= 1'b1;
        end
        // Strict compare keeps the lower bin on ties; bin 0 seeds the search
        if (s2_vld && ((s2_bin == '0) || (s2_mag > peak_mag_q))) begin
          peak_mag_q <= s2_mag;
          peak_bin_q <= s2_bin;
        end
      end

      s1_vld <= out_beat;
      if (out_beat) begin
        s1_re  <= signed'(bus.fft_m_tdata_re);
        s1_im  <= signed'(bus.fft_m_tdata_im);
        s1_bin <= out_cnt;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_mag <= mag_nxt;
        s2_bin <= s1_bin;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer at N=16: config stall, toggling source,
// peak search (unique peak, tie), tlast error, and mid-LOAD reset.
module tb_fft_frame_sequencer;

  localparam int LOG2_N = 4;
  localparam int DW     = 8;
  localparam int OW     = 24;
  localparam int CFG_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fft_frame_sequencer_if #(.LOG2_N(LOG2_N), .DW(DW), .OW(OW), .CFG_W(CFG_W)) bus ();

  fft_frame_sequencer #(.LOG2_N(LOG2_N), .DW(DW), .OW(OW), .CFG_W(CFG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bin contents the FFT model returns for each test pattern
  function automatic void bin_val(input int pat, input int k,
                                  output logic [OW-1:0] re, output logic [OW-1:0] im,
                                  output logic last);
    re   = OW'(k);
    im   = '0;
    last = (k == 15);
    case (pat)
      0: if (k == 5) begin re = OW'(100); im = OW'(-50); end
      1: begin
        if (k == 3) re = OW'(20);
        if (k == 9) begin re = '0; im = OW'(-20); end
      end
      2: begin
        if (k == 5) begin re = OW'(100); im = OW'(-50); end
        if (k == 7) last = 1'b1;
      end
      default: ;
    endcase
  endfunction

  task automatic run_frame(input logic fwd, input int cfg_stall, input int pat,
                           input int exp_bin, input longint exp_mag, input logic exp_err);
    int beats, k, cyc, n, tl;
    logic [OW-1:0] re, im;
    logic last;
    logic [DW-1:0] smp;

    bus.start = 1'b1; bus.fwd_inv = fwd;
    tick;
    bus.start = 1'b0; bus.fwd_inv = ~fwd;
    bus.src_tvalid = 1'b1; bus.fft_s_tready = 1'b1;
    #1;
    check("err_clr_on_start", bus.err_tlast, 0);
    check("peak_clr_on_start", bus.peak_mag, 0);
    check("busy_cfg", bus.busy, 1);

    for (int i = 0; i <= cfg_stall; i++) begin
      bus.cfg_tready = (i == cfg_stall);
      #1;
      check("cfg_tvalid", bus.cfg_tvalid, 1);
      check("cfg_tdata", bus.cfg_tdata, {7'd0, fwd});
      check("no_src_tready_in_cfg", bus.src_tready, 0);
      tick;
    end
    bus.cfg_tready = 1'b0;

    beats = 0; tl = 0; cyc = 0;
    while (beats < 16 && cyc < 200) begin
      smp = DW'(beats * 7 + 3);
      bus.src_tvalid = (cyc % 2 == 0);
      bus.src_tdata  = smp;
      #1;
      if (bus.src_tvalid && bus.src_tready) begin
        check("fft_s_tdata", bus.fft_s_tdata_re, smp);
        check("fft_s_tvalid", bus.fft_s_tvalid, 1);
        if (bus.fft_s_tlast) tl++;
        if (beats == 15) check("tlast_on_16th", bus.fft_s_tlast, 1);
        beats++;
      end
      tick;
      cyc++;
    end
    check("load_beats", beats, 16);
    check("tlast_count", tl, 1);
    bus.src_tvalid = 1'b1;
    #1;
    check("src_tready_after_load", bus.src_tready, 0);
    check("fft_s_tvalid_after_load", bus.fft_s_tvalid, 0);
    check("fft_m_tready_drain", bus.fft_m_tready, 1);
    bus.src_tvalid = 1'b0;

    k = 0; cyc = 0;
    while (k < 16 && cyc < 200) begin
      bin_val(pat, k, re, im, last);
      bus.fft_m_tvalid   = (cyc != 4);
      bus.fft_m_tdata_re = re;
      bus.fft_m_tdata_im = im;
      bus.fft_m_tlast    = last;
      #1;
      if (bus.fft_m_tvalid && bus.fft_m_tready) k++;
      tick;
      cyc++;
    end
    check("drain_beats", k, 16);
    bus.fft_m_tvalid = 1'b0; bus.fft_m_tlast = 1'b0;

    n = 1;
    while (bus.done !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    check("done_latency", n, 3);
    check("peak_bin", bus.peak_bin, exp_bin);
    check("peak_mag", bus.peak_mag, exp_mag);
    check("err_tlast", bus.err_tlast, exp_err);
    tick;
    check("done_one_cycle", bus.done, 0);
    check("busy_idle", bus.busy, 0);
  endtask

  initial begin
    bus.start = 0; bus.fwd_inv = 0; bus.src_tdata = '0; bus.src_tvalid = 0;
    bus.cfg_tready = 0; bus.fft_s_tready = 0; bus.fft_m_tdata_re = '0;
    bus.fft_m_tdata_im = '0; bus.fft_m_tvalid = 0; bus.fft_m_tlast = 0;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cfg_tvalid", bus.cfg_tvalid, 0);
    check("rst_peak_mag", bus.peak_mag, 0);
    check("rst_peak_bin", bus.peak_bin, 0);
    check("rst_err", bus.err_tlast, 0);

    // Unique peak at bin 5, config stalled 3 cycles
    run_frame(1'b1, 3, 0, 5, 64'd12500, 1'b0);
    tick; tick;
    check("peak_held_bin", bus.peak_bin, 5);
    check("peak_held_mag", bus.peak_mag, 12500);

    // Tie between bins 3 and 9 keeps bin 3; inverse direction config
    run_frame(1'b0, 0, 1, 3, 64'd400, 1'b0);

    // Early tlast at bin 7 sets sticky error, frame still completes
    run_frame(1'b1, 0, 2, 5, 64'd12500, 1'b1);
    tick;
    check("err_sticky", bus.err_tlast, 1);

    // Next start clears the error
    run_frame(1'b1, 1, 0, 5, 64'd12500, 1'b0);

    // Reset in LOAD after 6 accepted beats
    bus.start = 1'b1; bus.fwd_inv = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.cfg_tready = 1'b1; bus.src_tvalid = 1'b1; bus.fft_s_tready = 1'b1;
    tick;
    bus.cfg_tready = 1'b0;
    repeat (6) tick;
    #1;
    check("mid_load_active", bus.src_tready, 1);
    rst = 1'b1;
    tick;
    check("mrst_src_tready", bus.src_tready, 0);
    check("mrst_fft_s_tvalid", bus.fft_s_tvalid, 0);
    check("mrst_fft_s_tlast", bus.fft_s_tlast, 0);
    check("mrst_fft_s_tdata", bus.fft_s_tdata_re, 0);
    check("mrst_cfg_tvalid", bus.cfg_tvalid, 0);
    check("mrst_cfg_tdata", bus.cfg_tdata, 0);
    check("mrst_fft_m_tready", bus.fft_m_tready, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    check("mrst_peak_mag", bus.peak_mag, 0);
    check("mrst_peak_bin", bus.peak_bin, 0);
    check("mrst_err", bus.err_tlast, 0);
    rst = 1'b0;
    bus.src_tvalid = 1'b0; bus.fft_s_tready = 1'b0;
    tick;

    run_frame(1'b1, 1, 0, 5, 64'd12500, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Frame-level controller for the streaming FFT core.
- On `start`, it issues one config word, gates exactly N input samples into the core with a generated `tlast`, then drains the N output bins.
- While draining, it computes |X|² per bin and reports the peak bin.
- Sits between the sample source (DDS/ADC path) and the FFT wrapper; replaces ad-hoc `tlast`/`tvalid` generation in benches and top levels.

Parameters:
- LOG2_N, 10, log2 of transform length N (N = 1024 default).
- DW, 8, input sample width (signed, real part only; imaginary tied to 0 by this block).
- OW, 24, FFT output width per component (signed).
- CFG_W, 8, config word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle request to process one frame
- fwd_inv  in  1  1 = forward, 0 = inverse; sampled on accepted `start`
- src_tdata  in  DW  sample from source
- src_tvalid  in  1  source sample valid
- src_tready  out  1  source sample accepted when high with `src_tvalid`
- cfg_tdata  out  CFG_W  FFT config word; bit0 = latched `fwd_inv`, other bits 0
- cfg_tvalid  out  1  config valid
- cfg_tready  in  1  FFT config ready
- fft_s_tdata_re  out  DW  sample to FFT
- fft_s_tvalid  out  1  sample valid to FFT
- fft_s_tlast  out  1  marks sample N-1
- fft_s_tready  in  1  FFT input ready
- fft_m_tdata_re  in  OW  FFT output real
- fft_m_tdata_im  in  OW  FFT output imaginary
- fft_m_tvalid  in  1  FFT output valid
- fft_m_tlast  in  1  FFT output last
- fft_m_tready  out  1  ready to accept FFT output
- peak_bin  out  LOG2_N  index of max-magnitude bin
- peak_mag  out  2*OW+1  max |X|² value
- done  out  1  one-cycle pulse, frame complete
- busy  out  1  high in any state except IDLE
- err_tlast  out  1  sticky output-tlast mismatch

Behaviour:
- Clocking and reset: reset `rst`, synchronous, active-high; clock `clk`. Reset mid-operation returns to IDLE within one edge.
- Reset values: all outputs 0, counters cleared, peak registers cleared.
- State machine: IDLE -> CFG -> LOAD -> DRAIN -> FLUSH -> DONE -> IDLE.
- IDLE:
  - Waits for `start`; `start` in any other state is ignored.
  - On `start`, latches `fwd_inv`, clears `peak_mag`/`peak_bin`/`err_tlast`/counters, then goes to CFG.
- CFG:
  - `cfg_tvalid` = 1, held until `cfg_tready`; `cfg_tdata` is stable while valid.
  - Handshake cycle -> LOAD next cycle.
- LOAD: combinational pass-through, no added latency.
  - `fft_s_tdata_re` = `src_tdata`.
  - `fft_s_tvalid` = `src_tvalid`.
  - `src_tready` = `fft_s_tready`.
  - `fft_s_tlast` = (in_cnt == N-1).
  - in_cnt increments on each `src_tvalid` && `fft_s_tready`.
  - Beat N-1 accepted -> DRAIN, in_cnt wraps to 0.
  - Outside LOAD, `src_tready` = `fft_s_tvalid` = `fft_s_tlast` = 0.
- DRAIN:
  - `fft_m_tready` = 1; 0 in all other states.
  - Each accepted beat k (out_cnt = k) enters a 2-stage pipe:
    - stage1 registers re, im, k;
    - stage2 registers mag = re*re + im*im (signed products, unsigned sum, 2*OW+1 bits, no truncation) and k;
    - then compares with `peak_mag`.
  - Update rule: mag > `peak_mag` strictly; ties keep the lower bin. Bin 0 always loads.
  - `err_tlast` set if `fft_m_tlast` = 1 at out_cnt != N-1, or = 0 at out_cnt == N-1.
  - The frame always ends on out_cnt == N-1; the `tlast` value is ignored for sequencing.
  - Accepting beat N-1 -> FLUSH.
- FLUSH: 2 cycles, so the pipe empties and the last compare commits.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
  - Latency: the last output beat accepted at cycle t gives `done` high in cycle t+3.
- `peak_bin`/`peak_mag` are valid from `done` and held until the next accepted `start`.
- Stalls: `src_tvalid` low or `fft_s_tready` low in LOAD stalls in_cnt with no beat lost; `fft_m_tvalid` gaps stall out_cnt.

Optional Feature:
- Macro: FFT_SEQ_CONTINUOUS_EN.
- Defined:
  - DONE returns directly to CFG; a new frame starts automatically, reusing the latched `fwd_inv`.
  - `start` is still required once from IDLE.
  - `done` pulses once per frame.
  - Peak/err registers clear on entry to CFG.
  - `rst` is the only way back to IDLE.
- Undefined: DONE -> IDLE; one frame per `start`.

Test Plan:
- N=16 (LOG2_N=4), `start` with fwd_inv=1, `cfg_tready` held 0 for 3 cycles -> `cfg_tdata` = 0x01 stable with `cfg_tvalid` for 4 cycles; no `src_tready` before the handshake.
- Source delivers 16 samples with `src_tvalid` toggling every other cycle -> exactly 16 beats forwarded, `fft_s_tlast` only on the 16th, `src_tready` = 0 afterwards.
- FFT model returns bins with re=k, im=0 except bin 5 re=100, im=-50 -> `peak_bin`=5, `peak_mag`=12500, `done` 3 cycles after beat 15, `busy` drops the next cycle.
- Bins 3 and 9 both mag=400, all others smaller -> `peak_bin`=3.
- `fft_m_tlast` asserted at bin 7 -> `err_tlast`=1 sticky; frame still completes after bin 15; cleared by the next `start`.
- Assert `rst` mid-LOAD at in_cnt=6 -> next cycle all outputs 0, state IDLE. A subsequent `start` runs a clean 16-sample frame.
